// File: rtl/icw_ocw_sequencer.sv
// icw_ocw_sequencer: 8259A bus-write capture, ICW1-ICW4 init sequencing and OCW1-OCW3 decode.
// Ports:
//   clk, reset_bar              clock, asynchronous active-low reset
//   CS_bar, WR_bar, A0, data_in CPU write bus (A0/data latched while the strobe is active)
//   init_done, seq_state        READY flag and sequence state (0 UNINIT .. 4 READY)
//   icw1_pulse, ltim, sngl, ic4 ICW1 commit pulse and mode bits
//   vector_base, cascade_cfg    ICW2 T7..T3 and ICW3 byte
//   sfnm, buf_mode, ms, aeoi, upm  ICW4 fields
//   imr                         interrupt mask (OCW1)
//   ocw2_pulse/cmd/level        OCW2 commit pulse, R/SL/EOI and level
//   read_isr, poll_pulse, smm   OCW3 results
//   seq_error                   pulse on a rejected write
// Optional: define BUS_SYNC_EN to pass the bus inputs through 2-flop synchronizers.
module icw_ocw_sequencer #(
    parameter logic [7:0] IMR_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       reset_bar,
    input  logic       CS_bar,
    input  logic       WR_bar,
    input  logic       A0,
    input  logic [7:0] data_in,
    output logic       init_done,
    output logic [2:0] seq_state,
    output logic       icw1_pulse,
    output logic       ltim,
    output logic       sngl,
    output logic       ic4,
    output logic [4:0] vector_base,
    output logic [7:0] cascade_cfg,
    output logic       sfnm,
    output logic       buf_mode,
    output logic       ms,
    output logic       aeoi,
    output logic       upm,
    output logic [7:0] imr,
    output logic       ocw2_pulse,
    output logic [2:0] ocw2_cmd,
    output logic [2:0] ocw2_level,
    output logic       read_isr,
    output logic       poll_pulse,
    output logic       smm,
    output logic       seq_error
);
    typedef enum logic [2:0] {UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY} state_t;
    state_t     state_q;
    logic       cs_s, wr_s, a0_s;
    logic [7:0] d_s;
`ifdef BUS_SYNC_EN
    logic [1:0] cs_sync_q, wr_sync_q, a0_sync_q;
    logic [7:0] d_sync1_q, d_sync2_q;
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            cs_sync_q <= 2'b11;
            wr_sync_q <= 2'b11;
            a0_sync_q <= 2'b00;
            d_sync1_q <= 8'h00;
            d_sync2_q <= 8'h00;
        end else begin
            cs_sync_q <= {cs_sync_q[0], CS_bar};
            wr_sync_q <= {wr_sync_q[0], WR_bar};
            a0_sync_q <= {a0_sync_q[0], A0};
            d_sync1_q <= data_in;
            d_sync2_q <= d_sync1_q;
        end
    end
    assign cs_s = cs_sync_q[1];
    assign wr_s = wr_sync_q[1];
    assign a0_s = a0_sync_q[1];
    assign d_s  = d_sync2_q;
`else
    assign cs_s = CS_bar;
    assign wr_s = WR_bar;
    assign a0_s = A0;
    assign d_s  = data_in;
`endif
    logic       act_q, a0_lat_q;
    logic [7:0] d_lat_q;
    logic       wr_act, commit;
    assign wr_act = ~cs_s & ~wr_s;
    // Commit on the first edge that sees the strobe gone, using the last byte latched while it was active.
    assign commit = act_q & ~wr_act;
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            state_q     <= UNINIT;
            act_q       <= 1'b0;
            a0_lat_q    <= 1'b0;
            d_lat_q     <= 8'h00;
            icw1_pulse  <= 1'b0;
            ltim        <= 1'b0;
            sngl        <= 1'b0;
            ic4         <= 1'b0;
            vector_base <= 5'h00;
            cascade_cfg <= 8'h00;
            {sfnm, buf_mode, ms, aeoi, upm} <= 5'h00;
            imr         <= IMR_RESET;
            ocw2_pulse  <= 1'b0;
            ocw2_cmd    <= 3'h0;
            ocw2_level  <= 3'h0;
            read_isr    <= 1'b0;
            poll_pulse  <= 1'b0;
            smm         <= 1'b0;
            seq_error   <= 1'b0;
        end else begin
            act_q      <= wr_act;
            if (wr_act) begin
                a0_lat_q <= a0_s;
                d_lat_q  <= d_s;
            end
            icw1_pulse <= 1'b0;
            ocw2_pulse <= 1'b0;
            poll_pulse <= 1'b0;
            seq_error  <= 1'b0;
            if (commit) begin
                if (!a0_lat_q && d_lat_q[4]) begin
                    // ICW1 restarts initialization from any state; vector_base is deliberately kept.
                    state_q     <= WAIT_ICW2;
                    icw1_pulse  <= 1'b1;
                    {ltim, sngl, ic4} <= {d_lat_q[3], d_lat_q[1], d_lat_q[0]};
                    imr         <= IMR_RESET;
                    read_isr    <= 1'b0;
                    smm         <= 1'b0;
                    cascade_cfg <= 8'h00;
                    {sfnm, buf_mode, ms, aeoi, upm} <= 5'h00;
                end else if (state_q == WAIT_ICW2 && a0_lat_q) begin
                    vector_base <= d_lat_q[7:3];
                    state_q     <= !sngl ? WAIT_ICW3 : ic4 ? WAIT_ICW4 : READY;
                end else if (state_q == WAIT_ICW3 && a0_lat_q) begin
                    cascade_cfg <= d_lat_q;
                    state_q     <= ic4 ? WAIT_ICW4 : READY;
                end else if (state_q == WAIT_ICW4 && a0_lat_q) begin
                    {sfnm, buf_mode, ms, aeoi, upm} <= d_lat_q[4:0];
                    state_q <= READY;
                end else if (state_q == READY && a0_lat_q) begin
                    imr <= d_lat_q;
                end else if (state_q == READY && !d_lat_q[3]) begin
                    ocw2_pulse <= 1'b1;
                    ocw2_cmd   <= d_lat_q[7:5];
                    ocw2_level <= d_lat_q[2:0];
                end else if (state_q == READY) begin
                    read_isr   <= d_lat_q[1] ? d_lat_q[0] : read_isr;
                    smm        <= d_lat_q[6] ? d_lat_q[5] : smm;
                    poll_pulse <= d_lat_q[2];
                end else begin
                    seq_error <= 1'b1;
                end
            end
        end
    end
    assign seq_state = state_q;
    assign init_done = (state_q == READY);
endmodule

// File: tb/tb_icw_ocw_sequencer.sv
// tb_icw_ocw_sequencer: table-driven scoreboard bench for icw_ocw_sequencer.
module tb_icw_ocw_sequencer;
`ifdef BUS_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    logic       clk = 1'b0, reset_bar = 1'b0;
    logic       CS_bar = 1'b1, WR_bar = 1'b1, A0 = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       init_done, icw1_pulse, ltim, sngl, ic4, sfnm, buf_mode, ms, aeoi, upm;
    logic       ocw2_pulse, read_isr, poll_pulse, smm, seq_error;
    logic [2:0] seq_state, ocw2_cmd, ocw2_level;
    logic [4:0] vector_base;
    logic [7:0] cascade_cfg, imr;
    int total = 0, bad = 0;

    icw_ocw_sequencer dut (
        .clk(clk), .reset_bar(reset_bar), .CS_bar(CS_bar), .WR_bar(WR_bar), .A0(A0),
        .data_in(data_in), .init_done(init_done), .seq_state(seq_state),
        .icw1_pulse(icw1_pulse), .ltim(ltim), .sngl(sngl), .ic4(ic4),
        .vector_base(vector_base), .cascade_cfg(cascade_cfg), .sfnm(sfnm),
        .buf_mode(buf_mode), .ms(ms), .aeoi(aeoi), .upm(upm), .imr(imr),
        .ocw2_pulse(ocw2_pulse), .ocw2_cmd(ocw2_cmd), .ocw2_level(ocw2_level),
        .read_isr(read_isr), .poll_pulse(poll_pulse), .smm(smm), .seq_error(seq_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       a0;
        logic [7:0] d;
        logic [2:0] st;
        logic [2:0] icw1f;
        logic [4:0] vb;
        logic [7:0] cas;
        logic [4:0] icw4;
        logic [7:0] imr;
        logic [5:0] ocw2;
        logic       rd;
        logic       smm;
        logic [3:0] pul;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    logic [44:0] obs;
    assign obs = {seq_state, init_done, ltim, sngl, ic4, vector_base, cascade_cfg,
                  sfnm, buf_mode, ms, aeoi, upm, imr, ocw2_cmd, ocw2_level, read_isr, smm,
                  icw1_pulse, ocw2_pulse, poll_pulse, seq_error};

    function automatic logic [44:0] pk(vec_t v);
        return {v.st, v.st == 3'd4, v.icw1f, v.vb, v.cas, v.icw4, v.imr, v.ocw2, v.rd, v.smm, v.pul};
    endfunction

    task automatic chk(input string name, input logic [44:0] act, input logic [44:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic a0, input logic [7:0] d, input logic [2:0] st, input logic [2:0] f,
                       input logic [4:0] vb, input logic [7:0] cas, input logic [4:0] i4,
                       input logic [7:0] im, input logic [5:0] o2, input logic rd, input logic sm,
                       input logic [3:0] pul);
        vec_t v;
        v = '{a0, d, st, f, vb, cas, i4, im, o2, rd, sm, pul};
        tbl.push_back(v);
    endtask

    task automatic bus_write(input vec_t v, input int idx);
        sb.push_back(v);
        @(negedge clk);
        CS_bar = 1'b0; WR_bar = 1'b0; A0 = v.a0; data_in = v.d;
        @(negedge clk);
        CS_bar = 1'b1; WR_bar = 1'b1;
        repeat (LAT + 1) @(negedge clk);
        chk($sformatf("vec%0d", idx), obs, pk(sb.pop_front()));
        @(negedge clk);
        chk($sformatf("vec%0d_pulse_end", idx), {41'd0, obs[3:0]}, 45'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pc;
        // a0  d      st    ltim/sngl/ic4 vb    cas    icw4   imr    cmd,lvl      rd smm pulses
        add(1, 8'hFF, 3'd0, 3'b000, 5'h00, 8'h00, 5'h00, 8'h00, 6'b000_000, 0, 0, 4'b0001);
        add(0, 8'h08, 3'd0, 3'b000, 5'h00, 8'h00, 5'h00, 8'h00, 6'b000_000, 0, 0, 4'b0001);
        add(0, 8'h13, 3'd1, 3'b011, 5'h00, 8'h00, 5'h00, 8'h00, 6'b000_000, 0, 0, 4'b1000);
        add(1, 8'h48, 3'd3, 3'b011, 5'h09, 8'h00, 5'h00, 8'h00, 6'b000_000, 0, 0, 4'b0000);
        add(1, 8'h03, 3'd4, 3'b011, 5'h09, 8'h00, 5'h03, 8'h00, 6'b000_000, 0, 0, 4'b0000);
        add(1, 8'hA5, 3'd4, 3'b011, 5'h09, 8'h00, 5'h03, 8'hA5, 6'b000_000, 0, 0, 4'b0000);
        add(0, 8'h20, 3'd4, 3'b011, 5'h09, 8'h00, 5'h03, 8'hA5, 6'b001_000, 0, 0, 4'b0100);
        add(0, 8'h0B, 3'd4, 3'b011, 5'h09, 8'h00, 5'h03, 8'hA5, 6'b001_000, 1, 0, 4'b0000);
        add(0, 8'h6C, 3'd4, 3'b011, 5'h09, 8'h00, 5'h03, 8'hA5, 6'b001_000, 1, 1, 4'b0010);
        add(0, 8'hE5, 3'd4, 3'b011, 5'h09, 8'h00, 5'h03, 8'hA5, 6'b111_101, 1, 1, 4'b0100);
        add(0, 8'h11, 3'd1, 3'b001, 5'h09, 8'h00, 5'h00, 8'h00, 6'b111_101, 0, 0, 4'b1000);
        add(0, 8'h0A, 3'd1, 3'b001, 5'h09, 8'h00, 5'h00, 8'h00, 6'b111_101, 0, 0, 4'b0001);
        add(1, 8'h20, 3'd2, 3'b001, 5'h04, 8'h00, 5'h00, 8'h00, 6'b111_101, 0, 0, 4'b0000);
        add(0, 8'h08, 3'd2, 3'b001, 5'h04, 8'h00, 5'h00, 8'h00, 6'b111_101, 0, 0, 4'b0001);
        add(1, 8'h04, 3'd3, 3'b001, 5'h04, 8'h04, 5'h00, 8'h00, 6'b111_101, 0, 0, 4'b0000);
        add(1, 8'h01, 3'd4, 3'b001, 5'h04, 8'h04, 5'h01, 8'h00, 6'b111_101, 0, 0, 4'b0000);
        add(0, 8'h1B, 3'd1, 3'b111, 5'h04, 8'h00, 5'h00, 8'h00, 6'b111_101, 0, 0, 4'b1000);
        add(1, 8'hF8, 3'd3, 3'b111, 5'h1F, 8'h00, 5'h00, 8'h00, 6'b111_101, 0, 0, 4'b0000);
        add(0, 8'h1A, 3'd1, 3'b110, 5'h1F, 8'h00, 5'h00, 8'h00, 6'b111_101, 0, 0, 4'b1000);
        add(1, 8'h00, 3'd4, 3'b110, 5'h00, 8'h00, 5'h00, 8'h00, 6'b111_101, 0, 0, 4'b0000);

        repeat (3) @(negedge clk);
        chk("reset_state", obs, 45'd0);
        reset_bar = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_reset", obs, 45'd0);

        for (int i = 0; i < tbl.size(); i++) bus_write(tbl[i], i);

        // Long OCW1 strobe: data changes on the final cycle, only the last byte commits.
        @(negedge clk);
        CS_bar = 1'b0; WR_bar = 1'b0; A0 = 1'b1; data_in = 8'h11;
        repeat (4) @(negedge clk);
        chk("long_no_early_commit", {37'd0, imr}, 45'h00);
        data_in = 8'h3C;
        @(negedge clk);
        CS_bar = 1'b1; WR_bar = 1'b1;
        repeat (LAT + 1) @(negedge clk);
        chk("long_last_data", {37'd0, imr}, 45'h3C);

        // Long OCW2 strobe: the pulse appears exactly once.
        pc = 0;
        @(negedge clk);
        CS_bar = 1'b0; WR_bar = 1'b0; A0 = 1'b0; data_in = 8'h40;
        repeat (4) begin @(negedge clk); pc += int'(ocw2_pulse); end
        data_in = 8'h60;
        @(negedge clk);
        pc += int'(ocw2_pulse);
        CS_bar = 1'b1; WR_bar = 1'b1;
        repeat (LAT + 4) begin @(negedge clk); pc += int'(ocw2_pulse); end
        chk("long_ocw2_pulse_count", 45'(pc), 45'd1);
        chk("long_ocw2_cmd", {39'd0, ocw2_cmd, ocw2_level}, {39'd0, 6'b011_000});

        // CS_bar released before WR_bar still commits, and only once.
        @(negedge clk);
        CS_bar = 1'b0; WR_bar = 1'b0; A0 = 1'b1; data_in = 8'h5A;
        @(negedge clk);
        CS_bar = 1'b1;
        repeat (LAT + 1) @(negedge clk);
        chk("cs_first_commit", {37'd0, imr}, 45'h5A);
        WR_bar = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        chk("cs_first_no_recommit", {36'd0, seq_error, imr}, 45'h05A);

        // Reset in the middle of a strobe discards the write immediately.
        @(negedge clk);
        CS_bar = 1'b0; WR_bar = 1'b0; A0 = 1'b1; data_in = 8'h77;
        @(negedge clk);
        #2 reset_bar = 1'b0;
        #1 chk("async_reset_mid_strobe", obs, 45'd0);
        @(negedge clk);
        CS_bar = 1'b1; WR_bar = 1'b1;
        @(negedge clk);
        reset_bar = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        chk("no_commit_after_reset", obs, 45'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
